// File: rtl/vga_ball_shadow_regs.sv
// Double-buffered shadow registers between the Avalon-MM bus and the ball display peripheral.
// Shadow writes reach the peripheral only at the falling edge of VGA_VS or on an explicit commit.
module vga_ball_shadow_regs #(
  parameter int unsigned NREGS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       VGA_VS,
  output logic       ball_chipselect,
  output logic       ball_write,
  output logic [2:0] ball_address,
  output logic [7:0] ball_writedata
);

  localparam logic StIdle   = 1'b0;
  localparam logic StCommit = 1'b1;

  localparam logic [2:0] AddrCtrl   = 3'(NREGS);
  localparam logic [2:0] AddrStatus = 3'd4;
  localparam logic [2:0] AddrFrame  = 3'd5;
  localparam logic [1:0] IdxLast    = 2'(NREGS - 1);

  logic [NREGS-1:0][7:0] shadow_q, shadow_d;
  logic [NREGS-1:0][7:0] snap_q, snap_d;
  logic [NREGS-1:0]      dirty_q, dirty_d;
  logic [NREGS-1:0]      sdirty_q, sdirty_d;
  logic                  auto_q, auto_d;
  logic                  commit_req_q, commit_req_d;
  logic [7:0]            frame_q, frame_d;
  logic                  vs_q;
  logic                  state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic                  ball_cs_q, ball_cs_d;
  logic [2:0]            ball_addr_q, ball_addr_d;
  logic [7:0]            ball_wd_q, ball_wd_d;
  logic [7:0]            readdata_q, readdata_d;
  logic [7:0]            rdata_mux;

  logic wr_en, wr_shadow, wr_ctrl, rd_en;
  logic vs_fall, busy, trigger;

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign wr_shadow = wr_en && (address < AddrCtrl);
  assign wr_ctrl   = wr_en && (address == AddrCtrl);

  assign vs_fall = vs_q & ~VGA_VS;
  assign busy    = (state_q == StCommit);
  assign trigger = (vs_fall & auto_q & (|dirty_q)) | commit_req_q;

  always_comb begin
    shadow_d     = shadow_q;
    snap_d       = snap_q;
    dirty_d      = dirty_q;
    sdirty_d     = sdirty_q;
    auto_d       = auto_q;
    commit_req_d = commit_req_q;
    state_d      = state_q;
    idx_d        = idx_q;
    ball_cs_d    = 1'b0;
    ball_addr_d  = 3'd0;
    ball_wd_d    = 8'd0;

    // The output registers are loaded one beat ahead so beat 0 appears the cycle after the trigger.
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          snap_d       = shadow_q;
          sdirty_d     = dirty_q;
          dirty_d      = '0;
          commit_req_d = 1'b0;
          idx_d        = 2'd0;
          state_d      = StCommit;
          ball_cs_d    = dirty_q[0];
          ball_addr_d  = 3'd0;
          ball_wd_d    = shadow_q[0];
        end
      end
      StCommit: begin
        if (idx_q == IdxLast) begin
          state_d = StIdle;
        end else begin
          idx_d       = idx_q + 2'd1;
          ball_cs_d   = sdirty_q[idx_d];
          ball_addr_d = {1'b0, idx_d};
          ball_wd_d   = snap_q[idx_d];
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus writes are applied last so a write coinciding with the trigger keeps its dirty bit.
    if (wr_shadow) begin
      shadow_d[address[1:0]] = writedata;
      dirty_d[address[1:0]]  = 1'b1;
    end
    if (wr_ctrl) begin
      auto_d = writedata[0];
      if (writedata[1]) begin
        commit_req_d = 1'b1;
      end
    end
  end

  always_comb begin
    frame_d = frame_q;
    if (vs_fall) begin
      frame_d = frame_q + 8'd1;
    end
  end

  always_comb begin
    rdata_mux = 8'd0;
    if (address < AddrCtrl) begin
      rdata_mux = shadow_q[address[1:0]];
    end else begin
      case (address)
        AddrCtrl:   rdata_mux = {7'd0, auto_q};
        AddrStatus: rdata_mux = {5'd0, commit_req_q, busy, |dirty_q};
        AddrFrame:  rdata_mux = frame_q;
        default:    rdata_mux = 8'd0;
      endcase
    end
    readdata_d = rd_en ? rdata_mux : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q     <= '0;
      snap_q       <= '0;
      dirty_q      <= '0;
      sdirty_q     <= '0;
      auto_q       <= 1'b1;
      commit_req_q <= 1'b0;
      frame_q      <= 8'd0;
      vs_q         <= 1'b1;
      state_q      <= StIdle;
      idx_q        <= 2'd0;
      ball_cs_q    <= 1'b0;
      ball_addr_q  <= 3'd0;
      ball_wd_q    <= 8'd0;
      readdata_q   <= 8'd0;
    end else begin
      shadow_q     <= shadow_d;
      snap_q       <= snap_d;
      dirty_q      <= dirty_d;
      sdirty_q     <= sdirty_d;
      auto_q       <= auto_d;
      commit_req_q <= commit_req_d;
      frame_q      <= frame_d;
      vs_q         <= VGA_VS;
      state_q      <= state_d;
      idx_q        <= idx_d;
      ball_cs_q    <= ball_cs_d;
      ball_addr_q  <= ball_addr_d;
      ball_wd_q    <= ball_wd_d;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata        = readdata_q;
  assign ball_chipselect = ball_cs_q;
  assign ball_write      = ball_cs_q;
  assign ball_address    = ball_addr_q;
  assign ball_writedata  = ball_wd_q;

endmodule
